// File: rtl/mem_stage_if.sv
// mem_stage_if: EX->MEM and MEM->WB handshake/bus bundle for the memory stage.
// master = surrounding pipeline (EX, SRAM, WB side), slave = mem_stage.
interface mem_stage_if;

    localparam int unsigned EX_MEM_W = 108;
    localparam int unsigned MEM_WB_W = 102;
    localparam int unsigned MEM_ID_W = 38;
    localparam int unsigned DATA_W   = 32;

    logic                ex_mem_valid;
    logic                mem_allowin;
    logic [EX_MEM_W-1:0] ex_mem_bus;
    logic [DATA_W-1:0]   data_sram_rdata;
    logic                mem_wb_valid;
    logic                wb_allowin;
    logic [MEM_WB_W-1:0] mem_wb_bus;
    logic [MEM_ID_W-1:0] mem_id_bus;

    modport master (
        output ex_mem_valid,
        output ex_mem_bus,
        output data_sram_rdata,
        output wb_allowin,
        input  mem_allowin,
        input  mem_wb_valid,
        input  mem_wb_bus,
        input  mem_id_bus
    );

    modport slave (
        input  ex_mem_valid,
        input  ex_mem_bus,
        input  data_sram_rdata,
        input  wb_allowin,
        output mem_allowin,
        output mem_wb_valid,
        output mem_wb_bus,
        output mem_id_bus
    );

endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. Latches the EX payload, picks up the
// one-cycle-late SRAM read data, aligns/extends loads and feeds WB and ID bypass.
// Optional feature macro: MEM_RDATA_BUF_EN -- when defined, the first-cycle SRAM
// word is buffered so a WB stall cannot lose it; when undefined the live SRAM
// data is always used (loads correct only if WB never stalls a load in MEM).
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    mem_stage_if.slave   pipe
);

    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic        gr_we;
        logic        res_from_mem;
        logic [2:0]  mem_type;
        logic [1:0]  addr_low2;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] result;
    } ex_mem_t;

    localparam logic [2:0] MT_LD_B  = 3'b001;
    localparam logic [2:0] MT_LD_H  = 3'b010;
    localparam logic [2:0] MT_LD_BU = 3'b011;
    localparam logic [2:0] MT_LD_HU = 3'b100;

    logic              mem_valid;
    logic              mem_ready_go;
    logic              mem_allowin;
    logic              ex_to_mem;
    ex_mem_t           bus_r;
    logic [DATA_W-1:0] rdata;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] final_result;

    assign mem_ready_go = 1'b1;
    assign mem_allowin  = ~mem_valid | (mem_ready_go & pipe.wb_allowin);
    assign ex_to_mem    = pipe.ex_mem_valid & mem_allowin;

    // Stage valid: refreshed whenever the stage can accept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid <= pipe.ex_mem_valid;
        end
    end

    // Payload latch: only a real transfer overwrites it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_r <= '0;
        end else if (ex_to_mem) begin
            bus_r <= ex_mem_t'(pipe.ex_mem_bus);
        end
    end

`ifdef MEM_RDATA_BUF_EN
    logic              mem_first;
    logic [DATA_W-1:0] rdata_buf;

    // First-cycle flag: set by every transfer, so a new entry wins over a leave.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_first <= 1'b0;
        end else begin
            mem_first <= ex_to_mem;
        end
    end

    // Capture the SRAM response in the instruction's first MEM cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_buf <= '0;
        end else if (mem_valid & mem_first) begin
            rdata_buf <= pipe.data_sram_rdata;
        end
    end

    assign rdata = mem_first ? pipe.data_sram_rdata : rdata_buf;
`else
    assign rdata = pipe.data_sram_rdata;
`endif

    // Lane select and sign/zero extension; misaligned accesses use lanes as given.
    always_comb begin
        lane_byte = rdata[7:0];
        case (bus_r.addr_low2)
            2'd0: lane_byte = rdata[7:0];
            2'd1: lane_byte = rdata[15:8];
            2'd2: lane_byte = rdata[23:16];
            2'd3: lane_byte = rdata[31:24];
        endcase
        lane_half = bus_r.addr_low2[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (bus_r.mem_type)
            MT_LD_B:  load_data = {{24{lane_byte[7]}}, lane_byte};
            MT_LD_H:  load_data = {{16{lane_half[15]}}, lane_half};
            MT_LD_BU: load_data = {24'h0, lane_byte};
            MT_LD_HU: load_data = {16'h0, lane_half};
            default:  load_data = rdata;
        endcase
    end

    assign final_result = bus_r.res_from_mem ? load_data : bus_r.result;

    assign pipe.mem_allowin  = mem_allowin;
    assign pipe.mem_wb_valid = mem_valid & mem_ready_go;
    assign pipe.mem_wb_bus   = {bus_r.gr_we, bus_r.dest, bus_r.pc, bus_r.inst, final_result};
    assign pipe.mem_id_bus   = {mem_valid & bus_r.gr_we, bus_r.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed + randomized bench for mem_stage against a behavioural model.
module tb_mem_stage;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    mem_stage_if pipe ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .pipe   (pipe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the instruction sitting in MEM, how long it has been there, and
    // the SRAM word it saw on arrival.
    logic         m_valid;
    logic [107:0] m_bus;
    logic [31:0]  m_word;
    int           m_age;

    function automatic logic [107:0] mk(input logic gr_we, input logic rfm, input logic [2:0] t,
                                        input logic [1:0] a, input logic [4:0] dest,
                                        input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [31:0] res);
        return {gr_we, rfm, t, a, dest, pc, inst, res};
    endfunction

    // Load value from the rules: shift the addressed lane down, then extend.
    function automatic logic [31:0] exp_load(input logic [2:0] t, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(a))) & 32'h0000_00FF;
        h = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
        case (t)
            3'd1:    return (b >= 32'h80)   ? b - 32'h100   : b;
            3'd2:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] seen_word();
`ifdef MEM_RDATA_BUF_EN
        return (m_age == 0) ? pipe.data_sram_rdata : m_word;
`else
        return pipe.data_sram_rdata;
`endif
    endfunction

    function automatic logic [31:0] exp_final();
        if (m_bus[106]) return exp_load(m_bus[105:103], m_bus[102:101], seen_word());
        return m_bus[31:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_model();
        logic [31:0] f;
        f = exp_final();
        check("wb_valid", 128'(pipe.mem_wb_valid), 128'(m_valid));
        check("allowin",  128'(pipe.mem_allowin),  128'(!m_valid || pipe.wb_allowin));
        check("wb_bus",   128'(pipe.mem_wb_bus),
              128'({m_bus[107], m_bus[100:96], m_bus[95:64], m_bus[63:32], f}));
        check("id_bus",   128'(pipe.mem_id_bus),
              128'({m_valid & m_bus[107], m_bus[100:96], f}));
    endtask

    task automatic drive(input logic rn, input logic ev, input logic [107:0] eb,
                         input logic [31:0] rd, input logic wa);
        resetn               = rn;
        pipe.ex_mem_valid    = ev;
        pipe.ex_mem_bus      = eb;
        pipe.data_sram_rdata = rd;
        pipe.wb_allowin      = wa;
        #1;
        check_model();
    endtask

    task automatic tick();
        logic        accept;
        logic [31:0] rd;
        accept = !m_valid || pipe.wb_allowin;
        rd     = pipe.data_sram_rdata;
        @(posedge clk);
        if (!resetn) begin
            m_valid = 1'b0;
            m_bus   = '0;
            m_word  = '0;
            m_age   = 1;
        end else begin
            if (m_valid && m_age == 0) m_word = rd;
            if (pipe.ex_mem_valid && accept) begin
                m_bus = pipe.ex_mem_bus;
                m_age = 0;
            end else if (m_age < 1000) begin
                m_age++;
            end
            if (accept) m_valid = pipe.ex_mem_valid;
        end
        #1;
    endtask

    initial begin
        logic [107:0] nb;
        logic [31:0]  exp_stall;
        logic [31:0]  stall_rd [3];
        checks = 0;
        errors = 0;
        m_valid = 1'b0; m_bus = '0; m_word = '0; m_age = 1;
        resetn = 1'b0;
        pipe.ex_mem_valid = 1'b0; pipe.ex_mem_bus = '0;
        pipe.data_sram_rdata = '0; pipe.wb_allowin = 1'b1;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        drive(1'b1, 1'b0, '0, 32'h0, 1'b1);
        check("rst_wb_valid", 128'(pipe.mem_wb_valid), 128'(0));
        check("rst_allowin",  128'(pipe.mem_allowin),  128'(1));
        check("rst_id_bus",   128'(pipe.mem_id_bus),   128'(0));
        check("rst_wb_bus",   128'(pipe.mem_wb_bus),   128'(0));
        tick();

        // ld.w, a=0
        drive(1'b1, 1'b1, mk(1'b1, 1'b1, 3'd0, 2'd0, 5'd7, 32'h1c00_0000, 32'h2880_0000, 32'h0),
              32'hFFFF_FFFF, 1'b1);
        tick();
        drive(1'b1, 1'b0, '0, 32'h1234_5678, 1'b1);
        check("ldw_valid", 128'(pipe.mem_wb_valid), 128'(1));
        check("ldw_final", 128'(pipe.mem_wb_bus[31:0]), 128'(32'h1234_5678));
        check("ldw_we_dest", 128'({pipe.mem_wb_bus[101], pipe.mem_wb_bus[100:96]}), 128'({1'b1, 5'd7}));
        tick();

        // ld.b a=3 then ld.bu a=3 back-to-back
        drive(1'b1, 1'b1, mk(1'b1, 1'b1, 3'd1, 2'd3, 5'd3, 32'h10, 32'h11, 32'h0), 32'h0, 1'b1);
        tick();
        drive(1'b1, 1'b1, mk(1'b1, 1'b1, 3'd3, 2'd3, 5'd4, 32'h14, 32'h15, 32'h0), 32'h80AA_55CC, 1'b1);
        check("ldb", 128'(pipe.mem_wb_bus[31:0]), 128'(32'hFFFF_FF80));
        tick();
        drive(1'b1, 1'b0, '0, 32'h80AA_55CC, 1'b1);
        check("ldbu", 128'(pipe.mem_wb_bus[31:0]), 128'(32'h0000_0080));
        tick();

        // ld.h a=2 then ld.hu a=0
        drive(1'b1, 1'b1, mk(1'b1, 1'b1, 3'd2, 2'd2, 5'd8, 32'h20, 32'h21, 32'h0), 32'h0, 1'b1);
        tick();
        drive(1'b1, 1'b1, mk(1'b1, 1'b1, 3'd4, 2'd0, 5'd9, 32'h24, 32'h25, 32'h0), 32'h8001_7FFF, 1'b1);
        check("ldh", 128'(pipe.mem_wb_bus[31:0]), 128'(32'hFFFF_8001));
        tick();
        drive(1'b1, 1'b0, '0, 32'h8001_7FFF, 1'b1);
        check("ldhu", 128'(pipe.mem_wb_bus[31:0]), 128'(32'h0000_7FFF));
        tick();

        // WB stall on a load while EX keeps offering and rdata changes
        drive(1'b1, 1'b1, mk(1'b1, 1'b1, 3'd0, 2'd0, 5'd10, 32'h30, 32'h31, 32'h0), 32'h0, 1'b1);
        tick();
        nb = mk(1'b1, 1'b0, 3'd0, 2'd0, 5'd11, 32'h34, 32'h35, 32'h5555_5555);
        drive(1'b1, 1'b1, nb, 32'hA5A5_0F0F, 1'b0);
        check("stall_first", 128'(pipe.mem_wb_bus[31:0]), 128'(32'hA5A5_0F0F));
        tick();
        stall_rd[0] = 32'hDEAD_0000; stall_rd[1] = 32'h1111_1111; stall_rd[2] = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, nb, stall_rd[i], 1'b0);
`ifdef MEM_RDATA_BUF_EN
            exp_stall = 32'hA5A5_0F0F;
`else
            exp_stall = stall_rd[i];
`endif
            check("stall_hold", 128'(pipe.mem_wb_bus[31:0]), 128'(exp_stall));
            check("stall_allowin", 128'(pipe.mem_allowin), 128'(0));
            tick();
        end
        drive(1'b1, 1'b1, nb, 32'h0, 1'b1);
        tick();

        // Non-load: bypass with gr_we=1, then gr_we=0
        drive(1'b1, 1'b1, mk(1'b1, 1'b0, 3'd0, 2'd0, 5'd5, 32'h40, 32'h41, 32'hCAFE_F00D), 32'h0, 1'b1);
        tick();
        drive(1'b1, 1'b1, mk(1'b0, 1'b0, 3'd0, 2'd0, 5'd5, 32'h44, 32'h45, 32'hCAFE_F00D), 32'h0, 1'b1);
        check("bypass_on", 128'(pipe.mem_id_bus), 128'({1'b1, 5'd5, 32'hCAFE_F00D}));
        tick();
        drive(1'b1, 1'b0, '0, 32'h0, 1'b1);
        check("bypass_off", 128'(pipe.mem_id_bus[37]), 128'(0));
        tick();

        // Reset during a WB stall with a valid load
        drive(1'b1, 1'b1, mk(1'b1, 1'b1, 3'd0, 2'd1, 5'd12, 32'h50, 32'h51, 32'h0), 32'h0, 1'b1);
        tick();
        drive(1'b1, 1'b0, '0, 32'h7777_7777, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 32'h7777_7777, 1'b0);
        tick();
        drive(1'b1, 1'b0, '0, 32'h0, 1'b0);
        check("rststall_valid",   128'(pipe.mem_wb_valid), 128'(0));
        check("rststall_allowin", 128'(pipe.mem_allowin),  128'(1));
        check("rststall_id_bus",  128'(pipe.mem_id_bus),   128'(0));
        tick();

        // Randomized traffic with stalls and occasional resets
        for (int i = 0; i < 600; i++) begin
            nb = 108'({$urandom(), $urandom(), $urandom(), $urandom()});
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), nb,
                  $urandom(), ($urandom_range(0, 2) != 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
